// File: rtl/mem_channel_scheduler_if.sv
// Consumer-side and memory-side buses of the channel scheduler.
// slave is the scheduler's view; master is the LSU/memory environment.
interface mem_channel_scheduler_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic [NUM_CHANNELS-1:0]            mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]            mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]            mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]            mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address,
    input  consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address,
    output consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/mem_channel_scheduler.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS LSUs.
// Per-channel FSM plus one round-robin arbiter over idle channels.
module mem_channel_scheduler #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2
) (
  input logic                    clk,
  input logic                    reset,
  mem_channel_scheduler_if.slave bus
);
  localparam int CW = $clog2(NUM_CONSUMERS);

  typedef enum logic [2:0] {
    IDLE, READ_WAIT, WRITE_WAIT, RESPOND, RELEASE
  } state_e;

  state_e              state_q [NUM_CHANNELS];
  logic [CW-1:0]       owner_q [NUM_CHANNELS];
  logic [CW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_CHANNELS-1:0]            mem_rv_q, mem_wv_q;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_ra_q, mem_wa_q;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_wd_q;
  logic [NUM_CONSUMERS-1:0]           rd_rdy_q, wr_rdy_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q;

  logic [NUM_CONSUMERS-1:0] pending, owned, eligible;
  logic [NUM_CHANNELS-1:0]  grant_vld;
  logic [CW-1:0]            grant_idx [NUM_CHANNELS];

  assign pending  = bus.consumer_read_valid | bus.consumer_write_valid;
  assign eligible = pending & ~owned;

  always_comb begin
    owned = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] != IDLE) owned[owner_q[c]] = 1'b1;
    end
  end

  // Later channels see earlier grants, so the last grant is furthest in scan order.
  always_comb begin : arb
    logic [NUM_CONSUMERS-1:0] taken;
    logic                     found;
    logic [CW-1:0]            idx;
    taken     = '0;
    found     = 1'b0;
    idx       = '0;
    grant_vld = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      grant_idx[c] = '0;
      if (state_q[c] == IDLE) begin
        found = 1'b0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          idx = rr_ptr_q + CW'(k);
          if (!found && eligible[idx] && !taken[idx]) begin
            found        = 1'b1;
            taken[idx]   = 1'b1;
            grant_vld[c] = 1'b1;
            grant_idx[c] = idx;
            rr_ptr_d     = idx + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      mem_rv_q  <= '0;
      mem_wv_q  <= '0;
      mem_ra_q  <= '0;
      mem_wa_q  <= '0;
      mem_wd_q  <= '0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
      rd_data_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_rdy_q <= '0;
      wr_rdy_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        unique case (state_q[c])
          IDLE: begin
            if (grant_vld[c]) begin
              owner_q[c] <= grant_idx[c];
              if (bus.consumer_read_valid[grant_idx[c]]) begin
                state_q[c]  <= READ_WAIT;
                mem_rv_q[c] <= 1'b1;
                mem_ra_q[c*ADDR_BITS +: ADDR_BITS] <=
                  bus.consumer_read_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
              end else begin
                state_q[c]  <= WRITE_WAIT;
                mem_wv_q[c] <= 1'b1;
                mem_wa_q[c*ADDR_BITS +: ADDR_BITS] <=
                  bus.consumer_write_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                mem_wd_q[c*DATA_BITS +: DATA_BITS] <=
                  bus.consumer_write_data[grant_idx[c]*DATA_BITS +: DATA_BITS];
              end
            end
          end
          READ_WAIT: begin
            if (bus.mem_read_ready[c]) begin
              state_q[c]          <= RESPOND;
              mem_rv_q[c]         <= 1'b0;
              rd_rdy_q[owner_q[c]] <= 1'b1;
              rd_data_q[owner_q[c]*DATA_BITS +: DATA_BITS] <=
                bus.mem_read_data[c*DATA_BITS +: DATA_BITS];
            end
          end
          WRITE_WAIT: begin
            if (bus.mem_write_ready[c]) begin
              state_q[c]          <= RESPOND;
              mem_wv_q[c]         <= 1'b0;
              wr_rdy_q[owner_q[c]] <= 1'b1;
            end
          end
          RESPOND: state_q[c] <= RELEASE;
          // Hold ownership until the served request is withdrawn.
          RELEASE: begin
            if (!pending[owner_q[c]]) state_q[c] <= IDLE;
          end
          default: state_q[c] <= IDLE;
        endcase
      end
    end
  end

  assign bus.consumer_read_ready  = rd_rdy_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_rdy_q;
  assign bus.mem_read_valid       = mem_rv_q;
  assign bus.mem_read_address     = mem_ra_q;
  assign bus.mem_write_valid      = mem_wv_q;
  assign bus.mem_write_address    = mem_wa_q;
  assign bus.mem_write_data       = mem_wd_q;
endmodule

// File: tb/tb_mem_channel_scheduler.sv
// Directed scenarios plus random LSU/memory traffic against a
// transaction-level model of routing, data and fairness.
module tb_mem_channel_scheduler;
  localparam int AB = 8;
  localparam int DB = 16;
  localparam int NC = 4;
  localparam int NH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_channel_scheduler_if #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .NUM_CONSUMERS(NC), .NUM_CHANNELS(NH)
  ) bus ();

  mem_channel_scheduler #(
    .ADDR_BITS(AB), .DATA_BITS(DB),
    .NUM_CONSUMERS(NC), .NUM_CHANNELS(NH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DB-1:0] rfun(logic [AB-1:0] a);
    return {a ^ 8'h3C, a};
  endfunction

  function automatic logic [DB-1:0] wfun(logic [AB-1:0] a);
    return {~a, a ^ 8'h96};
  endfunction

  function automatic logic [AB-1:0] mra(int c);
    return bus.mem_read_address[c*AB +: AB];
  endfunction

  function automatic logic [AB-1:0] mwa(int c);
    return bus.mem_write_address[c*AB +: AB];
  endfunction

  function automatic logic [DB-1:0] mwd(int c);
    return bus.mem_write_data[c*DB +: DB];
  endfunction

  function automatic logic [DB-1:0] crd(int i);
    return bus.consumer_read_data[i*DB +: DB];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready         = '0;
    bus.mem_read_data          = '0;
    bus.mem_write_ready        = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_rd(int i, logic [AB-1:0] a);
    bus.consumer_read_valid[i]           = 1'b1;
    bus.consumer_read_address[i*AB +: AB] = a;
  endtask

  task automatic set_wr(int i, logic [AB-1:0] a, logic [DB-1:0] d);
    bus.consumer_write_valid[i]            = 1'b1;
    bus.consumer_write_address[i*AB +: AB] = a;
    bus.consumer_write_data[i*DB +: DB]    = d;
  endtask

  task automatic mem_rd_ack(int c, logic [DB-1:0] d);
    bus.mem_read_ready[c]          = 1'b1;
    bus.mem_read_data[c*DB +: DB]  = d;
  endtask

  task automatic test_single_read();
    do_reset();
    chk("rst_mrv", bus.mem_read_valid, 0);
    chk("rst_mwv", bus.mem_write_valid, 0);
    chk("rst_rrdy", bus.consumer_read_ready, 0);
    chk("rst_wrdy", bus.consumer_write_ready, 0);
    chk("rst_rdata", bus.consumer_read_data == '0, 1);
    chk("rst_ptr", dut.rr_ptr_q, 0);
    set_rd(2, 8'h10);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_mrv", bus.mem_read_valid, 2'b01);
      chk("t1_mra", mra(0), 8'h10);
      chk("t1_rrdy", bus.consumer_read_ready, 0);
    end
    mem_rd_ack(0, 16'hBEEF);
    tick();
    chk("t1_rrdy4", bus.consumer_read_ready, 4'b0100);
    chk("t1_data", crd(2), 16'hBEEF);
    chk("t1_mrv4", bus.mem_read_valid, 0);
    clr_in();
    tick();
    chk("t1_rrdy5", bus.consumer_read_ready, 0);
    chk("t1_hold", crd(2), 16'hBEEF);
    chk("t1_ptr", dut.rr_ptr_q, 3);
    tick();
    set_rd(1, 8'h21);
    tick();
    chk("t1_reuse_v", bus.mem_read_valid, 2'b01);
    chk("t1_reuse_a", mra(0), 8'h21);
  endtask

  task automatic test_parallel();
    do_reset();
    set_rd(0, 8'h01);
    set_rd(1, 8'h02);
    tick();
    chk("t2_mrv", bus.mem_read_valid, 2'b11);
    chk("t2_a0", mra(0), 8'h01);
    chk("t2_a1", mra(1), 8'h02);
    chk("t2_ptr", dut.rr_ptr_q, 2);
    mem_rd_ack(0, 16'h1111);
    mem_rd_ack(1, 16'h2222);
    tick();
    chk("t2_rrdy", bus.consumer_read_ready, 4'b0011);
    chk("t2_d0", crd(0), 16'h1111);
    chk("t2_d1", crd(1), 16'h2222);
    clr_in();
  endtask

  task automatic test_fairness();
    int order[$];
    int low[NC];
    int exp3[6] = '{0, 1, 2, 3, 0, 1};
    logic [NH-1:0] prev;
    do_reset();
    for (int i = 0; i < NC; i++) begin
      set_wr(i, AB'(i), DB'(i * 16'h111));
      low[i] = 0;
    end
    prev = '0;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      tick();
      for (int c = 0; c < NH; c++) begin
        if (bus.mem_write_valid[c] && !prev[c]) order.push_back(int'(mwa(c)));
      end
      prev = bus.mem_write_valid;
      bus.mem_write_ready = bus.mem_write_valid;
      for (int i = 0; i < NC; i++) begin
        if (bus.consumer_write_ready[i]) begin
          bus.consumer_write_valid[i] = 1'b0;
          low[i] = 2;
        end else if (low[i] > 0) begin
          low[i]--;
          if (low[i] == 0) bus.consumer_write_valid[i] = 1'b1;
        end
      end
    end
    chk("t3_cnt", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("t3_ord", (k < order.size()) ? order[k] : 99, exp3[k]);
    end
    clr_in();
  endtask

  task automatic test_read_priority();
    do_reset();
    set_rd(3, 8'h33);
    set_wr(3, 8'h44, 16'h1234);
    tick();
    chk("t4_mrv", bus.mem_read_valid, 2'b01);
    chk("t4_mwv", bus.mem_write_valid, 0);
    chk("t4_mra", mra(0), 8'h33);
    mem_rd_ack(0, 16'hABCD);
    tick();
    chk("t4_rrdy", bus.consumer_read_ready, 4'b1000);
    chk("t4_rdata", crd(3), 16'hABCD);
    chk("t4_wrdy", bus.consumer_write_ready, 0);
    clr_in();
    tick();
    chk("t4_mwv3", bus.mem_write_valid, 0);
    tick();
    chk("t4_mwv4", bus.mem_write_valid, 0);
    set_wr(3, 8'h44, 16'h1234);
    tick();
    chk("t4_mwv5", bus.mem_write_valid, 2'b01);
    chk("t4_mwa", mwa(0), 8'h44);
    chk("t4_mwd", mwd(0), 16'h1234);
    chk("t4_mrv5", bus.mem_read_valid, 0);
    bus.mem_write_ready = 2'b01;
    tick();
    chk("t4_wrdy6", bus.consumer_write_ready, 4'b1000);
    chk("t4_rrdy6", bus.consumer_read_ready, 0);
    clr_in();
  endtask

  task automatic test_slow_mem();
    do_reset();
    set_wr(1, 8'h55, 16'hCAFE);
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("t5_wait",
          {bus.mem_write_valid, mwa(0), mwd(0), bus.consumer_write_ready},
          {2'b01, 8'h55, 16'hCAFE, 4'b0000});
    end
    bus.mem_write_ready = 2'b01;
    tick();
    chk("t5_wrdy", bus.consumer_write_ready, 4'b0010);
    chk("t5_mwv", bus.mem_write_valid, 0);
    clr_in();
    tick();
    chk("t5_once", bus.consumer_write_ready, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_rd(0, 8'h61);
    set_rd(1, 8'h62);
    tick();
    chk("t6_mrv1", bus.mem_read_valid, 2'b11);
    tick();
    chk("t6_mrv2", bus.mem_read_valid, 2'b11);
    reset = 1'b1;
    clr_in();
    tick();
    chk("t6_mrv3", bus.mem_read_valid, 0);
    chk("t6_rrdy3", bus.consumer_read_ready, 0);
    chk("t6_ptr", dut.rr_ptr_q, 0);
    reset = 1'b0;
    mem_rd_ack(0, 16'h0BAD);
    mem_rd_ack(1, 16'h0BAD);
    tick();
    chk("t6_rrdy4", bus.consumer_read_ready, 0);
    chk("t6_mrv4", bus.mem_read_valid, 0);
    clr_in();
    set_rd(2, 8'h70);
    tick();
    chk("t6_new_v", bus.mem_read_valid, 2'b01);
    chk("t6_new_a", mra(0), 8'h70);
    mem_rd_ack(0, 16'h7777);
    tick();
    chk("t6_new_r", bus.consumer_read_ready, 4'b0100);
    chk("t6_new_d", crd(2), 16'h7777);
    clr_in();
  endtask

  task automatic run_random(int cycles);
    logic          act[NC];
    logic          op[NC];
    logic [AB-1:0] ca[NC];
    int            waitc[NC];
    int            idlec[NC];
    logic          seen_r[NH];
    logic          seen_w[NH];
    int            dr[NH];
    int            dw[NH];
    logic [AB-1:0] cr[NH];
    logic [AB-1:0] cw[NH];
    int            done = 0;
    int            id;
    int            cnt;
    do_reset();
    for (int i = 0; i < NC; i++) begin
      act[i] = 1'b0; op[i] = 1'b0; ca[i] = '0;
      waitc[i] = 0; idlec[i] = 2;
    end
    for (int c = 0; c < NH; c++) begin
      seen_r[c] = 1'b0; seen_w[c] = 1'b0;
      dr[c] = 0; dw[c] = 0; cr[c] = '0; cw[c] = '0;
    end
    for (int n = 0; n < cycles; n++) begin
      tick();
      bus.mem_read_ready  = '0;
      bus.mem_write_ready = '0;
      for (int i = 0; i < NC; i++) begin
        chk("rd_spur", bus.consumer_read_ready[i] & ~(act[i] & ~op[i]), 0);
        chk("wr_spur", bus.consumer_write_ready[i] & ~(act[i] & op[i]), 0);
        if (act[i] && ((!op[i] && bus.consumer_read_ready[i]) ||
                       (op[i] && bus.consumer_write_ready[i]))) begin
          if (!op[i]) chk("rd_data", crd(i), rfun(ca[i]));
          act[i] = 1'b0;
          idlec[i] = 0;
          done++;
          bus.consumer_read_valid[i]  = 1'b0;
          bus.consumer_write_valid[i] = 1'b0;
        end else if (act[i]) begin
          waitc[i]++;
          chk("starve", waitc[i] > 60, 0);
        end else begin
          idlec[i]++;
          if (idlec[i] >= 2 && ($urandom % 3) == 0) begin
            act[i] = 1'b1;
            op[i] = 1'($urandom);
            ca[i] = {6'($urandom), 2'(i)};
            waitc[i] = 0;
            if (op[i]) set_wr(i, ca[i], wfun(ca[i]));
            else set_rd(i, ca[i]);
          end
        end
      end
      for (int c = 0; c < NH; c++) begin
        chk("both_vld", bus.mem_read_valid[c] & bus.mem_write_valid[c], 0);
        if (bus.mem_read_valid[c]) begin
          if (!seen_r[c]) begin
            seen_r[c] = 1'b1;
            cr[c] = mra(c);
            dr[c] = $urandom_range(0, 4);
            id = int'(cr[c][1:0]);
            chk("rd_route", {act[id], op[id], ca[id]}, {1'b1, 1'b0, cr[c]});
          end
          chk("rd_hold", mra(c), cr[c]);
          if (dr[c] == 0) mem_rd_ack(c, rfun(cr[c]));
          else dr[c]--;
        end else begin
          seen_r[c] = 1'b0;
        end
        if (bus.mem_write_valid[c]) begin
          if (!seen_w[c]) begin
            seen_w[c] = 1'b1;
            cw[c] = mwa(c);
            dw[c] = $urandom_range(0, 4);
            id = int'(cw[c][1:0]);
            chk("wr_route", {act[id], op[id], ca[id]}, {1'b1, 1'b1, cw[c]});
          end
          chk("wr_hold", mwa(c), cw[c]);
          chk("wr_data", mwd(c), wfun(cw[c]));
          if (dw[c] == 0) bus.mem_write_ready[c] = 1'b1;
          else dw[c]--;
        end else begin
          seen_w[c] = 1'b0;
        end
      end
      for (int i = 0; i < NC; i++) begin
        cnt = 0;
        for (int c = 0; c < NH; c++) begin
          if (bus.mem_read_valid[c] && int'(mra(c) % NC) == i) cnt++;
          if (bus.mem_write_valid[c] && int'(mwa(c) % NC) == i) cnt++;
        end
        chk("dup_owner", cnt > 1, 0);
      end
    end
    chk("progress", done > 50, 1);
    clr_in();
  endtask

  initial begin
    clr_in();
    test_single_read();
    test_parallel();
    test_fairness();
    test_read_priority();
    test_slow_mem();
    test_reset_mid();
    run_random(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
